// File: rtl/pc_unit.sv
// Program counter for the RV32 fetch stage: selects trap / redirect / sequential
// next-PC, rejects misaligned or out-of-range candidates and parks in HALT.
module pc_unit #(
  parameter int unsigned          ADDR_W     = 32,
  parameter logic [ADDR_W-1:0]    IMEM_BASE  = 32'h0100_0000,
  parameter int unsigned          IMEM_WORDS = 512,
  parameter logic [ADDR_W-1:0]    TRAP_VEC   = 32'h0100_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr,
  input  logic              trap,
  input  logic              resume,
  output logic [ADDR_W-1:0] instr_addr,
  output logic [ADDR_W-1:0] epc,
  output logic              halt,
  output logic [1:0]        fault_cause,
  output logic [ADDR_W-1:0] fault_addr
);

  // Control handshake: we is a one-cycle advance strobe sampled on the rising
  // edge while in RUN; resume is a one-cycle strobe sampled only in HALT. There
  // is no back-pressure: every sampled strobe is consumed on that same edge.

  localparam logic [ADDR_W-1:0] LAST_ADDR = IMEM_BASE + ADDR_W'(4 * (IMEM_WORDS - 1));

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_MISALIGN = 2'b01,
    CAUSE_RANGE    = 2'b10
  } cause_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] epc_q, epc_d;
  cause_e            cause_q, cause_d;
  logic [ADDR_W-1:0] faddr_q, faddr_d;

  logic [ADDR_W:0]   seq_sum;
  logic              seq_wrap;
  logic [ADDR_W-1:0] cand;
  logic              cand_is_trap;
  logic              cand_is_redirect;
  logic              cand_misaligned;
  logic              cand_out_of_range;

  // One extra bit catches the carry out of the increment, so a wrapped PC
  // is rejected even if the wrapped value lands back inside the window.
  assign seq_sum  = {1'b0, pc_q} + {{(ADDR_W-2){1'b0}}, 3'd4};
  assign seq_wrap = seq_sum[ADDR_W];

  always_comb begin
    cand             = seq_sum[ADDR_W-1:0];
    cand_is_trap     = 1'b0;
    cand_is_redirect = 1'b0;
    if (trap) begin
      cand         = TRAP_VEC;
      cand_is_trap = 1'b1;
    end else if (redirect) begin
      cand             = redirect_addr;
      cand_is_redirect = 1'b1;
    end
  end

  always_comb begin
    cand_misaligned   = cand_is_redirect && (cand[1:0] != 2'b00);
    cand_out_of_range = (cand < IMEM_BASE) || (cand > LAST_ADDR) ||
                        (!cand_is_trap && !cand_is_redirect && seq_wrap);
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    cause_d = cause_q;
    faddr_d = faddr_q;
    case (state_q)
      S_RUN: begin
        if (we) begin
          if (cand_misaligned) begin
            cause_d = CAUSE_MISALIGN;
            faddr_d = cand;
            state_d = S_HALT;
          end else if (cand_out_of_range) begin
            cause_d = CAUSE_RANGE;
            faddr_d = cand;
            state_d = S_HALT;
          end else begin
            pc_d = cand;
            if (cand_is_trap) begin
              epc_d = pc_q;
            end
          end
        end
      end
      S_HALT: begin
        if (resume) begin
          pc_d    = IMEM_BASE;
          cause_d = CAUSE_NONE;
          faddr_d = '0;
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RUN;
      pc_q    <= IMEM_BASE;
      epc_q   <= '0;
      cause_q <= CAUSE_NONE;
      faddr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
      faddr_q <= faddr_d;
    end
  end

  // halt is the FSM state itself, so it doubles as the state debug view.
  assign instr_addr  = pc_q;
  assign epc         = epc_q;
  assign halt        = (state_q == S_HALT);
  assign fault_cause = cause_q;
  assign fault_addr  = faddr_q;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed vector table, long sequential run to the top of
// the window, and asynchronous reset between clock edges.
module tb_pc_unit;

  localparam int unsigned       AW         = 32;
  localparam logic [AW-1:0]     BASE       = 32'h0100_0000;
  localparam int unsigned       WORDS      = 512;
  localparam logic [AW-1:0]     TVEC       = 32'h0100_0200;
  localparam logic [AW-1:0]     LAST       = BASE + 32'(4 * (WORDS - 1));
  localparam int                W          = 3 * AW + 3;

  logic          clk;
  logic          rst;
  logic          we;
  logic          redirect;
  logic [AW-1:0] redirect_addr;
  logic          trap;
  logic          resume;
  logic [AW-1:0] instr_addr;
  logic [AW-1:0] epc;
  logic          halt;
  logic [1:0]    fault_cause;
  logic [AW-1:0] fault_addr;

  int n_cmp;
  int n_fail;

  logic [W-1:0] exp_q[$];

  typedef struct {
    logic          we;
    logic          redirect;
    logic [AW-1:0] raddr;
    logic          trap;
    logic          resume;
    logic [AW-1:0] e_pc;
    logic [AW-1:0] e_epc;
    logic          e_halt;
    logic [1:0]    e_cause;
    logic [AW-1:0] e_faddr;
  } vec_t;

  vec_t vecs[19];

  pc_unit #(
    .ADDR_W(AW), .IMEM_BASE(BASE), .IMEM_WORDS(WORDS), .TRAP_VEC(TVEC)
  ) dut (
    .clk(clk), .rst(rst), .we(we), .redirect(redirect),
    .redirect_addr(redirect_addr), .trap(trap), .resume(resume),
    .instr_addr(instr_addr), .epc(epc), .halt(halt),
    .fault_cause(fault_cause), .fault_addr(fault_addr)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run still active at time %0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  function automatic logic [W-1:0] pack(input logic [AW-1:0] pc, input logic [AW-1:0] ep,
                                        input logic h, input logic [1:0] c,
                                        input logic [AW-1:0] fa);
    return {pc, ep, h, c, fa};
  endfunction

  task automatic cmp(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at time %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: expected queue empty, nothing to compare", tag);
      return;
    end
    e = exp_q.pop_front();
    cmp({tag, ".instr_addr"},  instr_addr,          e[W-1 -: AW]);
    cmp({tag, ".epc"},         epc,                 e[2*AW+2 -: AW]);
    cmp({tag, ".halt"},        {31'd0, halt},       {31'd0, e[AW+2]});
    cmp({tag, ".fault_cause"}, {30'd0, fault_cause}, {30'd0, e[AW+1 -: 2]});
    cmp({tag, ".fault_addr"},  fault_addr,          e[AW-1:0]);
  endtask

  // ---------------- driver ----------------
  task automatic drive_idle();
    we = 1'b0; redirect = 1'b0; redirect_addr = '0; trap = 1'b0; resume = 1'b0;
  endtask

  task automatic step(input string tag, input vec_t v);
    @(negedge clk);
    we = v.we; redirect = v.redirect; redirect_addr = v.raddr;
    trap = v.trap; resume = v.resume;
    exp_q.push_back(pack(v.e_pc, v.e_epc, v.e_halt, v.e_cause, v.e_faddr));
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  function automatic vec_t mk(input logic w, input logic rd, input logic [AW-1:0] ra,
                              input logic tr, input logic rs, input logic [AW-1:0] pc,
                              input logic [AW-1:0] ep, input logic h, input logic [1:0] c,
                              input logic [AW-1:0] fa);
    vec_t v;
    v.we = w; v.redirect = rd; v.raddr = ra; v.trap = tr; v.resume = rs;
    v.e_pc = pc; v.e_epc = ep; v.e_halt = h; v.e_cause = c; v.e_faddr = fa;
    return v;
  endfunction

  // ---------------- test ----------------
  initial begin
    vec_t v;
    n_cmp = 0;
    n_fail = 0;
    drive_idle();

    //            we rd raddr          tr rs  pc                epc               h  c      faddr
    vecs[0]  = mk(1, 0, '0,            0, 0,  BASE + 32'h4,     '0,               0, 2'd0, '0);
    vecs[1]  = mk(1, 0, '0,            0, 0,  BASE + 32'h8,     '0,               0, 2'd0, '0);
    vecs[2]  = mk(1, 0, '0,            0, 0,  BASE + 32'hC,     '0,               0, 2'd0, '0);
    vecs[3]  = mk(1, 0, '0,            0, 0,  BASE + 32'h10,    '0,               0, 2'd0, '0);
    vecs[4]  = mk(1, 1, 32'h0100_0100, 0, 0,  32'h0100_0100,    '0,               0, 2'd0, '0);
    vecs[5]  = mk(1, 1, 32'h0100_0102, 0, 0,  32'h0100_0100,    '0,               1, 2'd1, 32'h0100_0102);
    vecs[6]  = mk(1, 1, 32'h0100_0200, 1, 0,  32'h0100_0100,    '0,               1, 2'd1, 32'h0100_0102);
    vecs[7]  = mk(0, 0, '0,            0, 1,  BASE,             '0,               0, 2'd0, '0);
    vecs[8]  = mk(0, 0, '0,            0, 1,  BASE,             '0,               0, 2'd0, '0);
    vecs[9]  = mk(0, 1, 32'h0100_0300, 1, 0,  BASE,             '0,               0, 2'd0, '0);
    vecs[10] = mk(1, 1, 32'h0100_0020, 0, 0,  32'h0100_0020,    '0,               0, 2'd0, '0);
    vecs[11] = mk(1, 1, 32'h0100_0040, 1, 0,  TVEC,             32'h0100_0020,    0, 2'd0, '0);
    vecs[12] = mk(1, 0, '0,            0, 1,  TVEC + 32'h4,     32'h0100_0020,    0, 2'd0, '0);
    vecs[13] = mk(1, 1, 32'h00FF_FFFC, 0, 0,  TVEC + 32'h4,     32'h0100_0020,    1, 2'd2, 32'h00FF_FFFC);
    vecs[14] = mk(0, 0, '0,            0, 1,  BASE,             32'h0100_0020,    0, 2'd0, '0);
    vecs[15] = mk(1, 1, 32'h0100_0800, 0, 0,  BASE,             32'h0100_0020,    1, 2'd2, 32'h0100_0800);
    vecs[16] = mk(0, 0, '0,            0, 1,  BASE,             32'h0100_0020,    0, 2'd0, '0);
    vecs[17] = mk(1, 1, 32'h0000_0001, 0, 0,  BASE,             32'h0100_0020,    1, 2'd1, 32'h0000_0001);
    vecs[18] = mk(1, 0, '0,            1, 1,  BASE,             32'h0100_0020,    0, 2'd0, '0);

    // reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(pack(BASE, '0, 1'b0, 2'd0, '0));
    check_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 19; i++) begin
      step($sformatf("vec%0d", i), vecs[i]);
    end

    // sequential run from BASE to LAST, then one advance past the top
    v = mk(1, 0, '0, 0, 0, BASE, 32'h0100_0020, 0, 2'd0, '0);
    for (int i = 1; i < int'(WORDS); i++) begin
      v.e_pc = BASE + 32'(4 * i);
      v.raddr = 32'($urandom_range(0, 32'hFFFF));
      step($sformatf("seq%0d", i), v);
    end
    v.e_pc = LAST; v.e_halt = 1'b1; v.e_cause = 2'd2; v.e_faddr = LAST + 32'h4;
    step("seq_over", v);

    // random strobes while halted leave everything unchanged
    for (int i = 0; i < 8; i++) begin
      v.we = 1'($urandom_range(0, 1));
      v.trap = 1'($urandom_range(0, 1));
      v.redirect = 1'($urandom_range(0, 1));
      v.raddr = BASE + 32'($urandom_range(0, 255) * 4);
      v.resume = 1'b0;
      step($sformatf("halt_hold%0d", i), v);
    end

    // resume, advance once, then assert rst between edges
    step("resume2", mk(0, 0, '0, 0, 1, BASE, 32'h0100_0020, 0, 2'd0, '0));
    step("post_resume", mk(1, 0, '0, 0, 0, BASE + 32'h4, 32'h0100_0020, 0, 2'd0, '0));
    step("trap2", mk(1, 0, '0, 1, 0, TVEC, BASE + 32'h4, 0, 2'd0, '0));
    step("bad_after_trap", mk(1, 1, 32'h0100_0006, 0, 0, TVEC, BASE + 32'h4, 1, 2'd1, 32'h0100_0006));
    @(negedge clk);
    drive_idle();
    #2;
    rst = 1'b1;
    #1;
    exp_q.push_back(pack(BASE, '0, 1'b0, 2'd0, '0));
    check_outputs("async_rst");
    @(negedge clk);
    rst = 1'b0;
    step("after_rst", mk(1, 0, '0, 0, 0, BASE + 32'h4, '0, 0, 2'd0, '0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
